lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to flag bad requests.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_t;

    // Illegal size, or an address that is not naturally aligned for its size.
    function automatic logic access_error(input size_t size, input logic [1:0] offset);
        case (size)
            SZ_B:    access_error = 1'b0;
            SZ_H:    access_error = offset[0];
            SZ_W:    access_error = (offset != 2'b00);
            default: access_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian byte-lane steering: extracts/extends load data from a memory
// word and merges sub-word store data into a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {offset, 3'b000};
    assign shifted = rdata >> shamt;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_B: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merged = rdata;
        case (size)
            SZ_B:    merged[shamt +: 8]  = wdata[7:0];
            SZ_H:    merged[shamt +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accepts one core request, performs a
// word access or a read-modify-write for sub-word stores, then holds the response.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_next;
    logic        we_q;
    size_t       size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        err;

    assign err = access_error(size_q, addr_q[1:0]);

    lsu_align u_align (
        .rdata       (mem_rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACCESS;
            ACCESS:  state_next = (err || !we_q || size_q == SZ_W) ? RESP : WRITE;
            WRITE:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are gated by rst so a reset mid-transaction never strobes memory.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!rst) begin
            case (state)
                IDLE:   req_ready = 1'b1;
                ACCESS: begin
                    mem_addr = {addr_q[31:2], 2'b00};
                    if (we_q && !err && size_q == SZ_W) begin
                        mem_wen   = 1'b1;
                        mem_wdata = wdata_q;
                    end
                end
                WRITE: begin
                    mem_addr  = {addr_q[31:2], 2'b00};
                    mem_wen   = 1'b1;
                    mem_wdata = merged_q;
                end
                RESP:    rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            merged_q   <= 32'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q       <= req_we;
                    size_q     <= size_t'(req_size);
                    unsigned_q <= req_unsigned;
                    addr_q     <= req_addr;
                    wdata_q    <= req_wdata;
                end
                ACCESS: begin
                    rsp_err   <= err;
                    rsp_rdata <= (err || we_q) ? 32'h0 : load_data;
                    if (!err && we_q && size_q != SZ_W) merged_q <= merged;
                end
                default: ;
            endcase
        end
    end

endmodule
